ram_stream_reader: RTL
======================

# ram_stream_reader

Read-side sequencer for the block RAMs in the first max-pool stage. On a start command it sweeps a contiguous run of words out of a RAM's registered read port (`en_r`, `addr_r`, `dat_read`) and presents them in order on a valid/ready stream to the pooling datapath. It absorbs the RAM's one-cycle read latency and downstream back-pressure without losing or duplicating words.

## Interface
Parameters:
- `A_WIDTH`, 7: log2 of RAM depth; addresses wrap modulo 2**A_WIDTH.
- `ADDR_WIDTH`, 10: width of `addr_r` and `base_addr`.
- `D_WIDTH`, 15: data word width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first word address; latched on accepted `start`.
- `count`  in  A_WIDTH+1  number of words, 0..2**A_WIDTH; latched on accepted `start`.
- `busy`  out  1  high while a command is in progress.
- `done`  out  1  one-cycle completion pulse.
- `en_r`  out  1  RAM read enable.
- `addr_r`  out  ADDR_WIDTH  RAM read address.
- `dat_read`  in  D_WIDTH  RAM read data, valid the cycle after `en_r`.
- `m_data`  out  D_WIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE, `start`=1, `count`≠0:
  - Latch `base_addr` and `count`.
  - Go to READ.
  - `busy`=1 from the next cycle.
- IDLE, `start`=1, `count`=0:
  - `done` pulses for one cycle on the next cycle.
  - No reads are issued.
  - `busy` stays 0.
- READ:
  - Issue a read (`en_r`=1) in a cycle iff words remain to issue AND outstanding < 4.
  - Outstanding = reads issued and not yet popped from the output stream.
  - k-th read address = (base_addr + k) mod 2**A_WIDTH, zero-extended to ADDR_WIDTH. Bits above A_WIDTH are ignored.
  - Go to DRAIN once the last read has been issued.
- Capture: the returning `dat_read` is written into a 4-entry output FIFO exactly one cycle after its `en_r`.
  - The FIFO can never overflow, by the credit rule above.
- Pop: a transfer happens when `m_valid`&&`m_ready`.
  - `m_data` is the FIFO head.
  - `m_data` and `m_valid` hold stable while `m_valid`=1 and `m_ready`=0.
- DRAIN: when the final word transfers, pulse `done` on the next cycle, drop `busy` in that same cycle, and return to IDLE.
- `start` while `busy`=1 is ignored, with no side effects.
- A pop and a capture in the same cycle are both honoured; FIFO occupancy is unchanged.
- Reset asserted mid-operation (asynchronous):
  - State returns to IDLE; all counters and FIFO pointers clear.
  - Any in-flight RAM data is discarded.
- `en_r`=0 whenever not in READ. `addr_r` value is don't-care when `en_r`=0, but is held at 0 in IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `en_r`=0, `addr_r`=0, `m_valid`=0, `m_data`=0.
- Start latency:
  - `start` sampled at edge E0.
  - `en_r`=1 with `addr_r`=base in cycle E0→E1.
  - RAM output valid after E1; captured in FIFO at E2.
  - `m_valid`=1 after E2, i.e. 3 cycles after `start` is sampled.
- Throughput: with `m_ready` held high, one word per cycle. N words complete in N+2 cycles after E0, and `done` follows 1 cycle later.
- Back-pressure: with `m_ready`=0, reads stop after outstanding reaches 4. Reads resume in the cycle after the first pop.
- `done` is always exactly one cycle wide.

## Structure
- Shared package `maxpool_pkg`:
  - state enum `rd_state_t` {IDLE, READ, DRAIN};
  - `localparam RD_FIFO_DEPTH = 4`.
- Sub-module `rd_skid_fifo`: parameterised D_WIDTH, depth RD_FIFO_DEPTH. It has push/pop, occupancy count, registered head output, and the same async active-low `reset`.
- The top level holds the FSM, address counter, remaining-word counter and outstanding counter.
- Testbench RAM model: 2**A_WIDTH deep, registered read, 1-cycle latency.

## Test plan
- `base_addr`=0, `count`=8, RAM[i]=i+0x100, `m_ready`=1 -> `m_data` 0x100..0x107 on 8 consecutive cycles starting 3 cycles after `start`; `done` 1 cycle after the last transfer.
- `base_addr`=124, `count`=6, A_WIDTH=7 -> `addr_r` 124,125,126,127,0,1; data order matches.
- `count`=16, `m_ready`=0 for 10 cycles then 1 -> exactly 4 `en_r` pulses during the stall; `m_data` held stable; all 16 words delivered in order with no duplicates.
- `m_ready` toggling 1,0,1,0 pseudo-randomly, `count`=128 -> scoreboard matches all 128 words; outstanding never exceeds 4.
- `count`=0 -> `done` pulse next cycle, no `en_r`, `busy`=0 throughout; a second `start` while `busy` (`count`=5) is ignored.
- `reset` driven low during a `count`=20 transfer at word 7 -> all outputs return to reset values immediately; a new `start` afterwards (`count`=3) delivers exactly 3 correct words.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared types and sizing for the first max-pool stage RAM read path.
package maxpool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam int RD_FIFO_DEPTH = 4;
  localparam int RD_PTR_W      = $clog2(RD_FIFO_DEPTH);
  localparam int RD_CNT_W      = RD_PTR_W + 1;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Valid/ready word stream from the RAM reader to the pooling datapath.
interface ram_stream_reader_if #(
  parameter int D_WIDTH = 15
);
  logic [D_WIDTH-1:0] m_data;
  logic               m_valid;
  logic               m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/rd_skid_fifo.sv
// Small output FIFO absorbing RAM read latency and stream back-pressure.
// The head is driven straight from the storage registers, so it carries no
// combinational path from push/pop and stays stable until popped.
module rd_skid_fifo
  import maxpool_pkg::*;
#(
  parameter int D_WIDTH = 15,
  parameter int DEPTH   = RD_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [D_WIDTH-1:0]           push_data,
  input  logic                         pop,
  output logic [D_WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]       occupancy
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Storage and write pointer; cleared so the stream shows zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on every accepted pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   rd_ptr <= '0;
    else if (pop) rd_ptr <= rd_ptr + 1'b1;
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ram_stream_reader.sv
// Sweeps a contiguous run of words out of a registered-read RAM and presents
// them in order on a valid/ready stream. Reads are credit limited so that the
// output FIFO can always accept the word returning one cycle after en_r.
module ram_stream_reader
  import maxpool_pkg::*;
#(
  parameter int A_WIDTH    = 7,
  parameter int ADDR_WIDTH = 10,
  parameter int D_WIDTH    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [A_WIDTH:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  en_r,
  output logic [ADDR_WIDTH-1:0] addr_r,
  input  logic [D_WIDTH-1:0]    dat_read,
  ram_stream_reader_if.master   m_strm
);
  rd_state_t            state;
  rd_state_t            state_nxt;
  logic [A_WIDTH-1:0]   addr_cnt;
  logic [A_WIDTH:0]     remain;
  logic [RD_CNT_W-1:0]  outst;
  logic [RD_CNT_W-1:0]  occ;
  logic                 vld_p1;
  logic                 issue;
  logic                 pop;
  logic                 accept;
  logic                 done_nxt;
  logic                 unused_hi_addr;

  // Address bits above the RAM depth do not take part in the sweep.
  assign unused_hi_addr = ^base_addr[ADDR_WIDTH-1:A_WIDTH];

  assign accept = (state == IDLE) && start && (count != '0);
  assign issue  = (state == READ) && (remain != '0) &&
                  (outst < RD_CNT_W'(RD_FIFO_DEPTH));
  assign pop    = m_strm.m_valid && m_strm.m_ready;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and completion decision.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) state_nxt = READ;
          else             done_nxt  = 1'b1;
        end
      end
      READ: begin
        if (issue && (remain == (A_WIDTH+1)'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && (outst == RD_CNT_W'(1))) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port and status outputs decoded from state.
  always_comb begin
    en_r   = issue;
    busy   = (state != IDLE);
    addr_r = (state == READ) ? ADDR_WIDTH'(addr_cnt) : '0;
  end

  // Registered one-cycle completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done <= 1'b0;
    else        done <= done_nxt;
  end

  // Address and remaining-word counters, loaded on an accepted command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_cnt <= '0;
      remain   <= '0;
    end else if (accept) begin
      addr_cnt <= base_addr[A_WIDTH-1:0];
      remain   <= count;
    end else if (issue) begin
      addr_cnt <= addr_cnt + 1'b1;
      remain   <= remain - 1'b1;
    end
  end

  // Outstanding reads: issued but not yet popped from the stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outst <= '0;
    end else begin
      unique case ({issue, pop})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end

  // p0 -> p1: RAM data is valid the cycle after en_r; reset drops it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= issue;
  end

  rd_skid_fifo #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (RD_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_p1),
    .push_data (dat_read),
    .pop       (pop),
    .head      (m_strm.m_data),
    .occupancy (occ)
  );

  assign m_strm.m_valid = (occ != '0);

endmodule
